// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit order,
// blank pattern and the active-low hex glyph table.
package seg7_pkg;

  // Segment bus is {g,f,e,d,c,b,a}, so segment a is bit 0.
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t HEX_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output seg_t       seg
);

  assign seg = HEX_PATTERN[value];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered loading, blanking,
// decimal points and anode dead time. Optional: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      seg_dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   pend_digits;
  logic [NUM_DIGITS-1:0]     pend_dp;
  logic [NUM_DIGITS-1:0]     pend_blank;
  logic                      pend_valid;
  logic [4*NUM_DIGITS-1:0]   act_digits;
  logic [NUM_DIGITS-1:0]     act_dp;
  logic [NUM_DIGITS-1:0]     act_blank;
  logic [NUM_DIGITS-1:0]     auto_blank;

  logic                      slot_end;
  logic                      wrap;
  logic                      commit;
  logic [4*NUM_DIGITS-1:0]   upd_digits;
  logic [NUM_DIGITS-1:0]     upd_dp;
  logic [NUM_DIGITS-1:0]     upd_blank;

  logic [3:0]                cur_digit;
  seg_t                      cur_pattern;
  logic [6:0]                seg_next;
  logic                      seg_dp_next;
  logic [NUM_DIGITS-1:0]     an_next;

  assign slot_end = (cnt == CNT_MAX);
  assign wrap     = slot_end && (idx == IDX_MAX);
  assign commit   = wrap && (load || pend_valid);

  // A load on the wrap cycle itself bypasses the pending buffer.
  assign upd_digits = load ? digits : pend_digits;
  assign upd_dp     = load ? dp     : pend_dp;
  assign upd_blank  = load ? blank  : pend_blank;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_valid  <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        pend_valid <= 1'b0;
        if (commit) begin
          act_digits <= upd_digits;
          act_dp     <= upd_dp;
          act_blank  <= upd_blank;
        end
      end else if (load) begin
        pend_digits <= digits;
        pend_dp     <= dp;
        pend_blank  <= blank;
        pend_valid  <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_next;
  logic                  seen_nonzero;

  // Digits above the most significant nonzero digit are suppressed; digit 0 never is.
  always_comb begin
    lz_next      = '0;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (upd_digits[4*i +: 4] != 4'h0) begin
        seen_nonzero = 1'b1;
      end
      lz_next[i] = ~seen_nonzero;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      auto_blank <= '0;
    end else if (commit) begin
      auto_blank <= lz_next;
    end
  end
`else
  assign auto_blank = '0;
`endif

  assign cur_digit = act_digits[4*int'(idx) +: 4];

  seg7_hex_decode u_decode (
    .value (cur_digit),
    .seg   (cur_pattern)
  );

  always_comb begin
    seg_next    = cur_pattern;
    seg_dp_next = ~act_dp[idx];
    an_next     = '1;
    if (act_blank[idx] || auto_blank[idx]) begin
      seg_next = SEG_OFF;
    end
    if (act_blank[idx]) begin
      seg_dp_next = 1'b1;
    end
    // The first cycle of every slot keeps all anodes off to avoid ghosting.
    if (cnt != '0) begin
      an_next[idx] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg    <= SEG_OFF;
      seg_dp <= 1'b1;
      an     <= '1;
      frame  <= 1'b0;
    end else begin
      seg    <= seg_next;
      seg_dp <= seg_dp_next;
      an     <= an_next;
      frame  <= wrap;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised time-multiplexed seven-segment display driver: scans NUM_DIGITS hex digits onto one shared active-low segment bus and per-digit active-low anodes. Replaces the fixed three-digit LED driver. Adds double-buffered tear-free loading, per-digit blanking, decimal points and anode dead time. Sits between the datapath, which produces the digit values, and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- PRESCALE, 16, clock cycles per digit slot (≥2)
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- digits  in  4*NUM_DIGITS  hex values, digit i = digits[4i+3:4i], digit 0 rightmost
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank  in  NUM_DIGITS  per-digit force blank, 1 = segments off
- load  in  1  capture digits/dp/blank into pending buffer
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- seg_dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  anodes, active-low, at most one low
- frame  out  1  one-cycle pulse at scan wrap

## Operation
- State: prescaler cnt (0..PRESCALE-1), digit index idx (0..NUM_DIGITS-1), pending buffer, active buffer, pending_valid flag.
- cnt increments every cycle; at PRESCALE-1 it wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 → 0.
- Scan wrap = cnt==PRESCALE-1 and idx==NUM_DIGITS-1.
- load=1: digits/dp/blank captured into pending, pending_valid set. Later loads before the wrap overwrite pending (last wins).
- On scan wrap with pending_valid: pending → active, pending_valid cleared. Active never changes mid-scan.
- load on the wrap cycle itself: the inputs of that cycle bypass pending straight into active; pending_valid ends cleared.
- Decode: hex → active-low pattern via shared table (0=0x40, 1=0x79, 8=0x00, F=0x0E; full 0..F in package).
- Digit blanked (seg=0x7F, seg_dp=1) when its blank bit is set in active. Anode still driven.
- Dead time: while cnt==0, an all ones (anti-ghosting); seg still shows the slot's digit.
- Otherwise an[idx]=0, other anodes 1.

## Timing
- Reset values: cnt=0, idx=0, active and pending all zero, pending_valid=0, seg=0x7F, seg_dp=1, an=all ones, frame=0.
- Outputs registered: seg/seg_dp/an/frame at edge t+1 reflect cnt/idx/active after edge t. One cycle latency.
- First cycle after reset deasserts: outputs are still reset values. Next cycle: slot 0 dead-time cycle (an all ones).
- frame high for exactly one cycle, in the output cycle following the scan-wrap state. Period NUM_DIGITS*PRESCALE.
- Loaded data first appears in the slot-0 output following the next wrap. Worst-case load-to-display latency is NUM_DIGITS*PRESCALE+1 cycles.
- reset mid-scan: all state and pending data discarded on that edge. No partial frame pulse.

## Configuration
- LEADING_ZERO_BLANK_EN defined: at active-buffer update, digits above the highest nonzero digit are additionally blanked. Digit 0 is never auto-blanked; value 0 shows a single "0". Explicit blank bits still apply, and dp on an auto-blanked digit stays lit.
- Undefined: only explicit blank bits blank. Zeros display as 0x40.

## Structure
- Package seg7_pkg: 16-entry active-low hex pattern constant, SEG_OFF=7'h7F, and the segment bit-order definition.
- One sub-module, seg7_hex_decode: combinational 4-bit → 7-bit lookup using the package table. The top instantiates it once on the muxed digit.
- Leading-zero mask computed once per active update and stored, not per slot.

## Test plan
- Reset held 5 cycles, NUM_DIGITS=3, PRESCALE=16 -> seg=0x7F, an=3'b111, seg_dp=1, frame=0 throughout.
- load digits=12'h108 at cycle 2, then free run -> after first wrap, slots give an=110/seg=0x00, an=101/seg=0x40, an=011/seg=0x79. An all ones on each slot's first cycle. frame every 48 cycles.
- Loads of 12'h123 then 12'h456 mid-scan -> 12'h123 never displayed. 12'h456 appears at slot 0 after the wrap, and no slot within a scan mixes values.
- load on the exact wrap cycle with 12'h0AF -> shown from the immediately following slot 0.
- With LEADING_ZERO_BLANK_EN, digits=12'h008 -> digits 1 and 2 seg=0x7F, digit 0 seg=0x00. digits=12'h000 -> digit 0 seg=0x40 only. Without the macro -> 0x40 on digits 1 and 2.
- reset asserted mid-slot 1 with pending_valid set -> next cycle all outputs at reset values. After release, active stays zero until a new load and wrap.
